// File: rtl/adc_readout_pkg.sv
// Shared types, constants and word builders for the ADC readout sequencer.
package adc_readout_pkg;

  localparam int N_CH   = 64;
  localparam int ADC_W  = 12;
  localparam int ADDR_W = 6;
  localparam int RD_LAT = 2;
  localparam int CH_W   = 6;
  localparam int NS_W   = 7;

  localparam logic [1:0] TY_HDR = 2'b10;
  localparam logic [1:0] TY_DAT = 2'b00;
  localparam logic [1:0] TY_TRL = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_WAIT,
    S_LOAD,
    S_SCAN,
    S_TRL
  } state_t;

  // 0 or anything above a full window means a full window
  function automatic logic [NS_W-1:0] eff_ns(
    input logic [NS_W-1:0] n
  );
    if (n == '0 || n > 7'd64) return 7'd64;
    return n;
  endfunction

  function automatic logic [31:0] mk_hdr(
    input logic [NS_W-1:0] ns,
    input logic [15:0]     id
  );
    return {TY_HDR, 3'b0, ns, 4'b0, id};
  endfunction

  function automatic logic [31:0] mk_dat(
    input logic [CH_W-1:0]   ch,
    input logic [ADDR_W-1:0] samp,
    input logic [ADC_W-1:0]  adc
  );
    return {TY_DAT, 6'b0, ch, samp, adc};
  endfunction

  function automatic logic [31:0] mk_trl(
    input logic [15:0] cnt
  );
    return {TY_TRL, 14'b0, cnt};
  endfunction

endpackage

// File: rtl/adc_readout_sched_oreg.sv
// Single-entry output register; contents hold while valid and not ready.
module adc_readout_sched_oreg (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ld_i,
  input  logic [31:0] data_i,
  input  logic        last_i,
  output logic        can_ld_o,
  output logic [31:0] out_data_o,
  output logic        out_valid_o,
  output logic        out_last_o,
  input  logic        out_ready_i
);

  logic [31:0] data_q;
  logic        valid_q;
  logic        last_q;

  assign can_ld_o    = !valid_q || out_ready_i;
  assign out_data_o  = data_q;
  assign out_valid_o = valid_q;
  assign out_last_o  = last_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (ld_i && can_ld_o) begin
      data_q  <= data_i;
      valid_q <= 1'b1;
      last_q  <= last_i;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end
  end

endmodule

// File: rtl/adc_readout_sched.sv
// L1-triggered readout sequencer: walks the event window, zero-suppresses
// channels and frames a header/data/trailer word stream.
module adc_readout_sched
  import adc_readout_pkg::*;
(
  input  logic                  rd_clk,
  input  logic                  rst_n,
  input  logic                  trig_l1,
  input  logic [NS_W-1:0]       n_samples,
  input  logic                  zs_en,
  input  logic [ADC_W-1:0]      zs_thr,
  output logic [ADDR_W-1:0]     adc_rd_addr,
  input  logic [N_CH*ADC_W-1:0] adc_data,
  output logic [31:0]           out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic [15:0]           trig_dropped
);

  state_t                  state_q;
  logic                    pend_q;
  logic [15:0]             drop_q;
  logic [15:0]             evid_q;
  logic [NS_W-1:0]         ns_q;
  logic                    zs_q;
  logic [ADC_W-1:0]        thr_q;
  logic [ADDR_W-1:0]       samp_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [CH_W-1:0]         ch_q;
  logic [1:0]              wcnt_q;
  logic [15:0]             dcnt_q;
  logic                    tsent_q;
  logic [N_CH*ADC_W-1:0]   shad_q;

  logic        can_ld;
  logic        ld_d;
  logic [31:0] word_d;
  logic        last_d;
  logic        go;
  logic        pass;
  logic        xfer;
  logic        last_samp;
  logic [ADC_W-1:0] cur_adc;

  assign cur_adc   = shad_q[ch_q*ADC_W +: ADC_W];
  assign pass      = !zs_q || (cur_adc > thr_q);
  assign xfer      = out_valid && out_ready;
  assign last_samp = ({1'b0, samp_q} == ns_q - 7'd1);
  assign go        = (state_q == S_IDLE) && (trig_l1 || pend_q) && can_ld;

  assign adc_rd_addr  = addr_q;
  assign busy         = (state_q != S_IDLE);
  assign trig_dropped = drop_q;

  always_comb begin
    ld_d   = 1'b0;
    word_d = '0;
    last_d = 1'b0;
    unique case (state_q)
      S_IDLE: if (go) begin
        ld_d   = 1'b1;
        word_d = mk_hdr(eff_ns(n_samples), evid_q);
      end
      S_SCAN: if (pass && can_ld) begin
        ld_d   = 1'b1;
        word_d = mk_dat(ch_q, samp_q, cur_adc);
      end
      S_TRL: if (!tsent_q && can_ld) begin
        ld_d   = 1'b1;
        word_d = mk_trl(dcnt_q);
        last_d = 1'b1;
      end
      default: ;
    endcase
  end

  adc_readout_sched_oreg u_oreg (
    .clk_i       (rd_clk),
    .rst_ni      (rst_n),
    .ld_i        (ld_d),
    .data_i      (word_d),
    .last_i      (last_d),
    .can_ld_o    (can_ld),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .out_last_o  (out_last),
    .out_ready_i (out_ready)
  );

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pend_q  <= 1'b0;
      drop_q  <= '0;
      evid_q  <= '0;
      ns_q    <= '0;
      zs_q    <= 1'b0;
      thr_q   <= '0;
      samp_q  <= '0;
      addr_q  <= '0;
      ch_q    <= '0;
      wcnt_q  <= '0;
      dcnt_q  <= '0;
      tsent_q <= 1'b0;
      shad_q  <= '0;
    end else begin
      // one trigger may queue behind the running event; more are dropped
      if (busy && trig_l1) begin
        if (!pend_q)
          pend_q <= 1'b1;
        else if (drop_q != 16'hFFFF)
          drop_q <= drop_q + 16'd1;
      end
      unique case (state_q)
        S_IDLE: if (go) begin
          pend_q  <= 1'b0;
          ns_q    <= eff_ns(n_samples);
          zs_q    <= zs_en;
          thr_q   <= zs_thr;
          samp_q  <= '0;
          addr_q  <= '0;
          dcnt_q  <= '0;
          state_q <= S_HDR;
        end
        S_HDR: if (xfer) begin
          evid_q  <= evid_q + 16'd1;
          wcnt_q  <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (wcnt_q == 2'(RD_LAT - 1))
            state_q <= S_LOAD;
          else
            wcnt_q <= wcnt_q + 2'd1;
        end
        S_LOAD: begin
          shad_q  <= adc_data;
          ch_q    <= '0;
          state_q <= S_SCAN;
        end
        S_SCAN: if (!pass || can_ld) begin
          if (pass)
            dcnt_q <= dcnt_q + 16'd1;
          if (ch_q == 6'd63) begin
            if (last_samp) begin
              tsent_q <= 1'b0;
              state_q <= S_TRL;
            end else begin
              samp_q  <= samp_q + 6'd1;
              addr_q  <= samp_q + 6'd1;
              wcnt_q  <= '0;
              state_q <= S_WAIT;
            end
          end else begin
            ch_q <= ch_q + 6'd1;
          end
        end
        S_TRL: begin
          if (tsent_q && xfer) begin
            addr_q  <= '0;
            state_q <= S_IDLE;
          end else if (ld_d) begin
            tsent_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
